ooo_reg_scoreboard: RTL

- Register-status table directly upstream of the OoO hazard unit. Tracks which architectural registers have an in-flight writer and which completion-buffer tag that writer holds.
- Drives the rs1_busy, rs2_busy and rd_busy hazard inputs for the instruction in decode.
- Marks a register busy when an instruction dispatches. Clears it on a tag-matched writeback. Clears every entry on a pipeline flush.

---
 rtl/rv32i_types_pkg.sv | 13 +
 rtl/sb_popcount.sv | 20 ++
 rtl/ooo_reg_scoreboard.sv | 119 +++++++++++
 3 files changed

// File: rtl/rv32i_types_pkg.sv
// Shared RV32I core types: register index, completion-buffer tag, scoreboard sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv32i_types_pkg;

  localparam int SB_NUM_REGS = 32;
  localparam int SB_TAG_W    = 4;
  localparam int SB_NUM_WB   = 2;

  typedef logic [SB_TAG_W-1:0] cb_tag_t;
  typedef logic [4:0]          reg_idx_t;

endpackage

// File: rtl/sb_popcount.sv
// Parameterised combinational population count of a bit vector.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: vec_i (W bits to count), cnt_o (OUT_W-bit count of set bits).
module sb_popcount #(
  parameter int W     = 32,
  parameter int OUT_W = 6
) (
  input  logic [W-1:0]     vec_i,
  output logic [OUT_W-1:0] cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < W; i++) begin
      cnt_o = cnt_o + OUT_W'(vec_i[i]);
    end
  end

endmodule

// File: rtl/ooo_reg_scoreboard.sv
// Register-status table: per-register in-flight flag plus completion-buffer tag of its writer.
// Latency: queries are combinational from state; set/clear/flush take effect on the next edge.
// Backpressure: none; the hazard unit stalls dispatch on rd_busy to avoid WAW overwrites.
// Optional macro SCOREBOARD_WB_BYPASS_EN: busy queries also read 0 for a register that a
// same-cycle writeback is clearing (register file must forward that writeback data).
// Ports: CLK/RST (async active-high); dispatch_* set an entry; rs1/rs2/rd are decode queries
// returning rs1_busy/rs2_busy/rd_busy and rs1_tag/rs2_tag; wb_valid/wb_rd/wb_tag are packed
// per-port writebacks; flush clears all busy bits; all_idle/busy_count summarise occupancy.
module ooo_reg_scoreboard
  import rv32i_types_pkg::*;
#(
  parameter int NUM_REGS = SB_NUM_REGS,
  parameter int TAG_W    = SB_TAG_W,
  parameter int NUM_WB   = SB_NUM_WB
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    dispatch_valid,
  input  logic                    dispatch_wen,
  input  reg_idx_t                dispatch_rd,
  input  logic [TAG_W-1:0]        dispatch_tag,
  input  reg_idx_t                rs1,
  input  reg_idx_t                rs2,
  input  reg_idx_t                rd,
  input  logic [NUM_WB-1:0]       wb_valid,
  input  logic [NUM_WB*5-1:0]     wb_rd,
  input  logic [NUM_WB*TAG_W-1:0] wb_tag,
  input  logic                    flush,
  output logic                    rs1_busy,
  output logic                    rs2_busy,
  output logic                    rd_busy,
  output logic [TAG_W-1:0]        rs1_tag,
  output logic [TAG_W-1:0]        rs2_tag,
  output logic                    all_idle,
  output logic [5:0]              busy_count
);

  logic [NUM_REGS-1:0]            busy_q, busy_d;
  logic [NUM_REGS-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [5:0]                     cnt_q, cnt_d;

  logic [NUM_REGS-1:0]            clr_vec;
  logic [NUM_REGS-1:0]            live;
  logic                           dispatch_hit;

  assign dispatch_hit = dispatch_valid && dispatch_wen && (dispatch_rd != '0);

  // A writeback only retires the entry if its tag still owns the register;
  // a mismatch means a younger writer has since taken it over.
  always_comb begin
    clr_vec = '0;
    for (int p = 0; p < NUM_WB; p++) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (wb_valid[p] && (wb_rd[p*5 +: 5] == reg_idx_t'(r)) && busy_q[r] &&
            (tag_q[r] == wb_tag[p*TAG_W +: TAG_W])) begin
          clr_vec[r] = 1'b1;
        end
      end
    end
  end

  // Flush beats everything (tags are left alone); a dispatch set beats a clear of the same reg.
  always_comb begin
    busy_d = busy_q;
    tag_d  = tag_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      busy_d = busy_q & ~clr_vec;
      if (dispatch_hit) begin
        busy_d[dispatch_rd] = 1'b1;
        tag_d[dispatch_rd]  = dispatch_tag;
      end
    end
    busy_d[0] = 1'b0;
    tag_d[0]  = '0;
  end

  sb_popcount #(
    .W     (NUM_REGS),
    .OUT_W (6)
  ) u_popcount (
    .vec_i (busy_d),
    .cnt_o (cnt_d)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      busy_q <= '0;
      tag_q  <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      tag_q  <= tag_d;
      cnt_q  <= cnt_d;
    end
  end

`ifdef SCOREBOARD_WB_BYPASS_EN
  assign live = busy_q & ~clr_vec;
`else
  assign live = busy_q;
`endif

  assign rs1_busy   = (rs1 != '0) && live[rs1];
  assign rs2_busy   = (rs2 != '0) && live[rs2];
  assign rd_busy    = (rd  != '0) && live[rd];
  assign rs1_tag    = (rs1 != '0) ? tag_q[rs1] : '0;
  assign rs2_tag    = (rs2 != '0) ? tag_q[rs2] : '0;
  assign busy_count = cnt_q;
  assign all_idle   = (cnt_q == '0);

`ifndef SYNTHESIS
  // Dispatching over a live writer silently drops the older tag; rd_busy should have stalled it.
  a_no_waw_dispatch: assert property (@(posedge CLK) disable iff (RST)
    !(dispatch_hit && !flush && busy_q[dispatch_rd] && !clr_vec[dispatch_rd]));
`endif

endmodule
